// File: rtl/tdm_demux8_pkg.sv
// Shared constants and FSM state type for the 8-slot TDM receive path.
package tdm_demux_pkg;
  localparam int unsigned NSLOT = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/tdm_demux8_if.sv
// Beat-in / frame-out handshake bundle for tdm_demux8.
interface tdm_demux8_if #(
  parameter int unsigned WIDTH = 1
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_sof;
  logic               out_valid;
  logic               out_ready;
  logic [8*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/tdm_demux8_dec3to8.sv
// Gated 3-to-8 one-hot decoder used for slot write enables and slot_oh.
module dec3to8
  import tdm_demux_pkg::*;
(
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [NSLOT-1:0] o_oh
);
  always_comb begin
    o_oh = '0;
    if (i_en) o_oh[i_sel] = 1'b1;
  end
endmodule

// File: rtl/tdm_demux8.sv
// 8-slot TDM receiver: steers beats into slot registers, emits whole frames.
// Optional counters enabled by defining TDM_DEMUX_STATS_EN.
module tdm_demux8
  import tdm_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  tdm_demux8_if.slave      bus,
  output logic [NSLOT-1:0] slot_oh,
  output logic             sync_err
`ifdef TDM_DEMUX_STATS_EN
  ,
  output logic [7:0]       frame_cnt,
  output logic [7:0]       err_cnt
`endif
);
  state_t                  r_state;
  logic [SEL_W-1:0]        r_cnt;
  logic [WIDTH-1:0]        r_shadow [NSLOT-1];
  logic [NSLOT*WIDTH-1:0]  r_out_data;
  logic                    r_out_valid;
  logic                    r_sync_err;

  logic                    w_run;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_restart;
  logic                    w_lost;
  logic                    w_frame_done;
  logic [NSLOT-1:0]        w_we;
  logic [NSLOT*WIDTH-1:0]  w_frame;

  assign w_run      = (r_state == RUN);
  // Only the closing beat stalls: the frame register is the sole buffer.
  assign w_in_ready = ~(w_run && (r_cnt == SEL_W'(NSLOT-1)) && r_out_valid && !bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  assign w_restart    = w_accept & w_run & (r_cnt != '0) & bus.in_sof;
  assign w_lost       = w_accept & w_run & (r_cnt == '0) & ~bus.in_sof;
  assign w_frame_done = w_accept & w_run & (r_cnt == SEL_W'(NSLOT-1)) & ~bus.in_sof;

  dec3to8 u_dec_we (
    .i_sel (r_cnt),
    .i_en  (w_accept & w_run),
    .o_oh  (w_we)
  );

  dec3to8 u_dec_oh (
    .i_sel (r_cnt),
    .i_en  (w_run),
    .o_oh  (slot_oh)
  );

  always_comb begin
    w_frame = '0;
    for (int unsigned k = 0; k < NSLOT - 1; k++) w_frame[k*WIDTH +: WIDTH] = r_shadow[k];
    w_frame[(NSLOT-1)*WIDTH +: WIDTH] = bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= HUNT;
      r_cnt       <= '0;
      for (int unsigned k = 0; k < NSLOT - 1; k++) r_shadow[k] <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_sync_err <= w_restart | w_lost;
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        if (!w_run) begin
          if (bus.in_sof) begin
            r_shadow[0] <= bus.in_data;
            r_cnt       <= SEL_W'(1);
            r_state     <= RUN;
          end
        end else if (w_restart) begin
          r_shadow[0] <= bus.in_data;
          r_cnt       <= SEL_W'(1);
        end else if (w_lost) begin
          r_state <= HUNT;
        end else begin
          for (int unsigned k = 0; k < NSLOT - 1; k++)
            if (w_we[k]) r_shadow[k] <= bus.in_data;
          r_cnt <= r_cnt + SEL_W'(1);
          if (w_frame_done) begin
            r_out_data  <= w_frame;
            r_out_valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef TDM_DEMUX_STATS_EN
  logic [7:0] r_frame_cnt;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_frame_done && r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 8'd1;
      if ((w_restart || w_lost) && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign sync_err      = r_sync_err;
endmodule

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8 (WIDTH=1).
module tb_tdm_demux8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] slot_oh;
  logic       sync_err;
`ifdef TDM_DEMUX_STATS_EN
  logic [7:0] frame_cnt;
  logic [7:0] err_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_sync   = 0;
  logic [7:0]  q_frames [$];

  tdm_demux8_if #(.WIDTH(1)) bus ();

  tdm_demux8 #(.WIDTH(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .slot_oh  (slot_oh),
    .sync_err (sync_err)
`ifdef TDM_DEMUX_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (sync_err) n_sync++;
      if (bus.out_valid && bus.out_ready) q_frames.push_back(bus.out_data);
    end
  end

  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 1'b0; bus.in_sof = 1'b0;
    bus.out_ready = ready;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    q_frames.delete();
    n_sync = 0;
  endtask

  task automatic beat(input logic d, input logic s);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_sof = s;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v);
    beat(v[0], 1'b1);
    for (int k = 1; k < 8; k++) beat(v[k], 1'b0);
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || slot_oh !== 8'h00 || sync_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: valid=%b data=%h oh=%h err=%b, required 0/00/00/0",
               bus.out_valid, bus.out_data, slot_oh, sync_err);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic;
    logic [7:0] bits;
    bits = 8'b0100_1101;
    do_reset(1'b1);
    beat(bits[0], 1'b1);
    n_checks++;
    if (slot_oh !== 8'h02) begin
      n_errors++;
      $display("FAIL basic_slot_oh: got %h, required 02", slot_oh);
    end
    for (int k = 1; k < 8; k++) beat(bits[k], 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4D) begin
      n_errors++;
      $display("FAIL basic_frame: valid=%b data=%h, required 1/4d", bus.out_valid, bus.out_data);
    end
    n_checks++;
    if (slot_oh !== 8'h01) begin
      n_errors++;
      $display("FAIL basic_wrap_oh: got %h, required 01", slot_oh);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_one_cycle: out_valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_hunt_drop;
    do_reset(1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    n_checks++;
    if (slot_oh !== 8'h00) begin
      n_errors++;
      $display("FAIL hunt_oh: got %h, required 00", slot_oh);
    end
    send_frame(8'hA5);
    @(posedge clk); #1;
    n_checks++;
    if (n_sync !== 0 || q_frames.size() !== 1) begin
      n_errors++;
      $display("FAIL hunt_counts: sync=%0d frames=%0d, required 0/1", n_sync, q_frames.size());
    end else begin
      n_checks++;
      if (q_frames[0] !== 8'hA5) begin
        n_errors++;
        $display("FAIL hunt_data: got %h, required a5", q_frames[0]);
      end
    end
  endtask

  task automatic test_resync;
    logic [7:0] v;
    v = 8'h6E;
    do_reset(1'b1);
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(v[0], 1'b1);
    n_checks++;
    if (sync_err !== 1'b1 || slot_oh !== 8'h02) begin
      n_errors++;
      $display("FAIL resync_pulse: err=%b oh=%h, required 1/02", sync_err, slot_oh);
    end
    for (int k = 1; k < 8; k++) beat(v[k], 1'b0);
    n_checks++;
    if (bus.out_data !== 8'h6E || n_sync !== 1) begin
      n_errors++;
      $display("FAIL resync_frame: data=%h sync=%0d, required 6e/1", bus.out_data, n_sync);
    end
`ifdef TDM_DEMUX_STATS_EN
    n_checks++;
    if (frame_cnt !== 8'd1 || err_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL resync_stats: frames=%0d errs=%0d, required 1/1", frame_cnt, err_cnt);
    end
`endif
  endtask

  task automatic test_back_pressure;
    logic [7:0] f2;
    f2 = 8'hC3;
    do_reset(1'b0);
    send_frame(8'h3C);
    beat(f2[0], 1'b1);
    for (int k = 1; k < 7; k++) beat(f2[k], 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      n_errors++;
      $display("FAIL bp_hold: valid=%b data=%h, required 1/3c", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = f2[7]; bus.in_sof = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_stall: in_ready=%b, required 0", bus.in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_data !== 8'h3C || slot_oh !== 8'h80) begin
      n_errors++;
      $display("FAIL bp_stable: data=%h oh=%h, required 3c/80", bus.out_data, slot_oh);
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release: in_ready=%b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC3) begin
      n_errors++;
      $display("FAIL bp_same_edge: valid=%b data=%h, required 1/c3", bus.out_valid, bus.out_data);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (q_frames.size() !== 2) begin
      n_errors++;
      $display("FAIL bp_count: frames=%0d, required 2", q_frames.size());
    end else begin
      n_checks++;
      if (q_frames[0] !== 8'h3C || q_frames[1] !== 8'hC3) begin
        n_errors++;
        $display("FAIL bp_order: got %h,%h, required 3c,c3", q_frames[0], q_frames[1]);
      end
    end
  endtask

  task automatic test_lost_sync;
    do_reset(1'b1);
    send_frame(8'h81);
    beat(1'b1, 1'b0);
    n_checks++;
    if (sync_err !== 1'b1 || slot_oh !== 8'h00) begin
      n_errors++;
      $display("FAIL lost_sync: err=%b oh=%h, required 1/00", sync_err, slot_oh);
    end
    @(posedge clk); #1;
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_errors++;
      $display("FAIL lost_pulse_width: err=%b, required 0", sync_err);
    end
    beat(1'b0, 1'b1);
    n_checks++;
    if (slot_oh !== 8'h02) begin
      n_errors++;
      $display("FAIL lost_relock: oh=%h, required 02", slot_oh);
    end
  endtask

  task automatic test_mid_reset;
    do_reset(1'b0);
    send_frame(8'hFF);
    beat(1'b1, 1'b1);
    for (int k = 1; k < 5; k++) beat(1'b1, 1'b0);
    n_checks++;
    if (slot_oh !== 8'h20 || bus.out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_pre: oh=%h valid=%b, required 20/1", slot_oh, bus.out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || slot_oh !== 8'h00) begin
      n_errors++;
      $display("FAIL midrst_async: valid=%b oh=%h, required 0/00", bus.out_valid, slot_oh);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    q_frames.delete();
    send_frame(8'h96);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h96) begin
      n_errors++;
      $display("FAIL midrst_frame: valid=%b data=%h, required 1/96", bus.out_valid, bus.out_data);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 1'b0; bus.in_sof = 1'b0; bus.out_ready = 1'b1;
    test_reset;
    test_basic;
    test_hunt_drop;
    test_resync;
    test_back_pressure;
    test_lost_sync;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
